frame_wr: RTL and testbench

- Write-side counterpart of the DDR2 frame-buffer line reader.
- Accepts a raster pixel stream from the fractal engine and packs 16-bit pixels into 32-bit words.
- Double-buffers complete display lines in two on-chip line banks.
- Issues one write request per line to ddr2_mgr and supplies the line's words when the controller pulls them.

---
 rtl/frame_wr.sv | 227 ++++++++++++++++++++++
 tb/tb_frame_wr.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_wr.sv
// Packs a 16-bit raster pixel stream into 32-bit words, ping-pongs complete lines
// across two line banks and hands each finished line to ddr2_mgr as one write burst.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no transfer; waiting for the oldest full bank
// WAIT_GRANT | wr_mem_req raised with address/length; waiting for grant
// PRE_XFR    | word 0 of the drain bank loaded onto wr_data
// DATA_XFR   | wr_data valid; each wr_data_rd consumes one word
`timescale 1ns/1ps
module frame_wr #(
    parameter logic [9:0] XFR_LEN_PER_LINE = 10'h200,
    parameter int         ROW_W            = 13,
    parameter int         COL_W            = 10,
    parameter int         BANK_W           = 2
) (
    input  logic                            mem_clk0,
    input  logic                            mem_rst_n,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic [15:0]                     pix_data,
    input  logic                            pix_sol,
    input  logic [ROW_W-1:0]                pix_row,
    output logic                            wr_mem_req,
    output logic [ROW_W+COL_W+BANK_W-1:0]   wr_mem_addr,
    output logic [9:0]                      wr_xfr_len,
    input  logic                            wr_mem_grant,
    input  logic                            wr_data_rd,
    output logic [31:0]                     wr_data,
    output logic                            line_done,
    output logic                            wr_frame_fault
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_GRANT = 2'd1;
    localparam logic [1:0] ST_PRE_XFR    = 2'd2;
    localparam logic [1:0] ST_DATA_XFR   = 2'd3;
    localparam logic [8:0] LAST_WORD     = 9'(XFR_LEN_PER_LINE - 10'd1);

    logic [31:0] bank0_mem [512];
    logic [31:0] bank1_mem [512];

    logic [1:0]       state_q, state_d;
    logic             wr_mem_req_q, wr_mem_req_d;
    logic [ROW_W+COL_W+BANK_W-1:0] wr_mem_addr_q, wr_mem_addr_d;
    logic [9:0]       wr_xfr_len_q, wr_xfr_len_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             line_done_q, line_done_d;
    logic             fault_q, fault_d;
    logic [1:0]       full_q, full_d;
    logic             fill_bank_q, fill_bank_d;
    logic [8:0]       fill_ptr_q, fill_ptr_d;
    logic             phase_q, phase_d;
    logic [15:0]      hold_q, hold_d;
    logic [ROW_W-1:0] cur_row_q, cur_row_d;
    logic [ROW_W-1:0] row0_q, row0_d;
    logic [ROW_W-1:0] row1_q, row1_d;
    logic             drain_bank_q, drain_bank_d;
    logic [8:0]       drain_ptr_q, drain_ptr_d;

    logic             accept;
    logic             we_en;
    logic [31:0]      we_data;
    logic             rd_en;
    logic [8:0]       rd_addr;
    logic [31:0]      rd_word;
    logic [ROW_W-1:0] drain_row;

    // The fill bank is never full while pix_ready is high, so a fill never lands on the draining bank.
    assign pix_ready = ~(full_q[0] & full_q[1]);
    assign accept    = pix_valid & pix_ready;
    assign rd_word   = drain_bank_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
    assign drain_row = drain_bank_q ? row1_q : row0_q;

    always_comb begin
        state_d       = state_q;
        wr_mem_req_d  = wr_mem_req_q;
        wr_mem_addr_d = wr_mem_addr_q;
        wr_xfr_len_d  = wr_xfr_len_q;
        line_done_d   = 1'b0;
        fault_d       = fault_q;
        full_d        = full_q;
        fill_bank_d   = fill_bank_q;
        fill_ptr_d    = fill_ptr_q;
        phase_d       = phase_q;
        hold_d        = hold_q;
        cur_row_d     = cur_row_q;
        row0_d        = row0_q;
        row1_d        = row1_q;
        drain_bank_d  = drain_bank_q;
        drain_ptr_d   = drain_ptr_q;
        we_en         = 1'b0;
        we_data       = {pix_data, hold_q};
        rd_en         = 1'b0;
        rd_addr       = 9'd0;

        case (state_q)
            ST_IDLE: begin
                if (full_q[drain_bank_q]) begin
                    state_d = ST_WAIT_GRANT;
                end
            end
            ST_WAIT_GRANT: begin
                if (!wr_mem_req_q) begin
                    wr_mem_req_d  = 1'b1;
                    wr_mem_addr_d = {drain_row, {COL_W{1'b0}}, {BANK_W{1'b0}}};
                    wr_xfr_len_d  = XFR_LEN_PER_LINE;
                end else if (wr_mem_grant) begin
                    wr_mem_req_d = 1'b0;
                    rd_en        = 1'b1;
                    drain_ptr_d  = 9'd0;
                    state_d      = ST_PRE_XFR;
                end
            end
            ST_PRE_XFR: begin
                state_d = ST_DATA_XFR;
            end
            default: begin
                if (wr_data_rd) begin
                    if (drain_ptr_q == LAST_WORD) begin
                        full_d[drain_bank_q] = 1'b0;
                        drain_bank_d         = ~drain_bank_q;
                        drain_ptr_d          = 9'd0;
                        line_done_d          = 1'b1;
                        state_d              = ST_IDLE;
                    end else begin
                        drain_ptr_d = drain_ptr_q + 9'd1;
                        rd_en       = 1'b1;
                        rd_addr     = drain_ptr_q + 9'd1;
                    end
                end
            end
        endcase

        if (wr_data_rd && (state_q != ST_DATA_XFR)) begin
            fault_d = 1'b1;
        end

        if (accept) begin
            if (pix_sol) begin
                if ((fill_ptr_q != 9'd0) || phase_q) begin
                    fault_d = 1'b1;
                end
                cur_row_d  = pix_row;
                fill_ptr_d = 9'd0;
                hold_d     = pix_data;
                phase_d    = 1'b1;
            end else if (!phase_q) begin
                hold_d  = pix_data;
                phase_d = 1'b1;
            end else begin
                we_en      = 1'b1;
                phase_d    = 1'b0;
                fill_ptr_d = fill_ptr_q + 9'd1;
                if (fill_ptr_q == LAST_WORD) begin
                    full_d[fill_bank_q] = 1'b1;
                    fill_bank_d         = ~fill_bank_q;
                    if (fill_bank_q) begin
                        row1_d = cur_row_q;
                    end else begin
                        row0_d = cur_row_q;
                    end
                end
            end
        end
    end

    assign wr_data_d = rd_en ? rd_word : wr_data_q;

    always_ff @(posedge mem_clk0) begin
        if (we_en) begin
            if (fill_bank_q) begin
                bank1_mem[fill_ptr_q] <= we_data;
            end else begin
                bank0_mem[fill_ptr_q] <= we_data;
            end
        end
    end

    always_ff @(posedge mem_clk0 or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state_q       <= ST_IDLE;
            wr_mem_req_q  <= 1'b0;
            wr_mem_addr_q <= '0;
            wr_xfr_len_q  <= '0;
            wr_data_q     <= '0;
            line_done_q   <= 1'b0;
            fault_q       <= 1'b0;
            full_q        <= 2'b00;
            fill_bank_q   <= 1'b0;
            fill_ptr_q    <= 9'd0;
            phase_q       <= 1'b0;
            hold_q        <= 16'd0;
            cur_row_q     <= '0;
            row0_q        <= '0;
            row1_q        <= '0;
            drain_bank_q  <= 1'b0;
            drain_ptr_q   <= 9'd0;
        end else begin
            state_q       <= state_d;
            wr_mem_req_q  <= wr_mem_req_d;
            wr_mem_addr_q <= wr_mem_addr_d;
            wr_xfr_len_q  <= wr_xfr_len_d;
            wr_data_q     <= wr_data_d;
            line_done_q   <= line_done_d;
            fault_q       <= fault_d;
            full_q        <= full_d;
            fill_bank_q   <= fill_bank_d;
            fill_ptr_q    <= fill_ptr_d;
            phase_q       <= phase_d;
            hold_q        <= hold_d;
            cur_row_q     <= cur_row_d;
            row0_q        <= row0_d;
            row1_q        <= row1_d;
            drain_bank_q  <= drain_bank_d;
            drain_ptr_q   <= drain_ptr_d;
        end
    end

    assign wr_mem_req     = wr_mem_req_q;
    assign wr_mem_addr    = wr_mem_addr_q;
    assign wr_xfr_len     = wr_xfr_len_q;
    assign wr_data        = wr_data_q;
    assign line_done      = line_done_q;
    assign wr_frame_fault = fault_q;

endmodule

// File: tb/tb_frame_wr.sv
// Directed bench for frame_wr: table of whole-line vectors plus hand-written
// sequences for reset, backpressure and stray wr_data_rd pulses.
`timescale 1ns/1ps
module tb_frame_wr;

    logic        mem_clk0 = 1'b0;
    logic        mem_rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [15:0] pix_data = 16'd0;
    logic        pix_sol = 1'b0;
    logic [12:0] pix_row = 13'd0;
    logic        wr_mem_req;
    logic [24:0] wr_mem_addr;
    logic [9:0]  wr_xfr_len;
    logic        wr_mem_grant = 1'b0;
    logic        wr_data_rd = 1'b0;
    logic [31:0] wr_data;
    logic        line_done;
    logic        wr_frame_fault;

    int n_chk  = 0;
    int n_fail = 0;

    frame_wr dut (
        .mem_clk0       (mem_clk0),
        .mem_rst_n      (mem_rst_n),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_data       (pix_data),
        .pix_sol        (pix_sol),
        .pix_row        (pix_row),
        .wr_mem_req     (wr_mem_req),
        .wr_mem_addr    (wr_mem_addr),
        .wr_xfr_len     (wr_xfr_len),
        .wr_mem_grant   (wr_mem_grant),
        .wr_data_rd     (wr_data_rd),
        .wr_data        (wr_data),
        .line_done      (line_done),
        .wr_frame_fault (wr_frame_fault)
    );

    always #5 mem_clk0 = ~mem_clk0;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [12:0] row;
        int          pre;
        logic [12:0] row2;
        bit          stall;
        logic [24:0] exp_addr;
        bit          exp_fault;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk0);
        #1;
    endtask

    task automatic do_reset();
        pix_valid = 1'b0; pix_sol = 1'b0; wr_mem_grant = 1'b0; wr_data_rd = 1'b0;
        mem_rst_n = 1'b0;
        tick(); tick();
        mem_rst_n = 1'b1;
        tick();
    endtask

    task automatic send_pix(input logic [15:0] d, input bit sol, input logic [12:0] row);
        int cyc = 0;
        pix_valid = 1'b1; pix_data = d; pix_sol = sol; pix_row = row;
        while (!pix_ready && cyc < 4000) begin
            tick();
            cyc++;
        end
        if (!pix_ready) chk("pix_ready_wait", {63'd0, pix_ready}, 64'd1);
        tick();
    endtask

    task automatic send_line(input int base, input logic [12:0] row);
        for (int i = 0; i < 1024; i++) send_pix(16'(base + i), i == 0, row);
        pix_valid = 1'b0;
        pix_sol   = 1'b0;
    endtask

    task automatic wait_req();
        int cyc = 0;
        while (!wr_mem_req && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("req_wait", {63'd0, wr_mem_req}, 64'd1);
    endtask

    // Grants the pending request and consumes one full line, checking every word.
    task automatic drain(input int base, input bit stall, input bit pre_pulse,
                         output int mism, output int dones,
                         output bit rdy_before, output bit rdy_after);
        int k = 0;
        int cyc = 0;
        logic [31:0] exp;
        mism = 0; dones = 0; rdy_before = 1'b0;
        wr_mem_grant = 1'b1;
        tick();
        wr_mem_grant = 1'b0;
        wr_data_rd = pre_pulse;
        tick();
        while (k < 512 && cyc < 4000) begin
            wr_data_rd = stall ? (cyc % 2 == 0) : 1'b1;
            if (wr_data_rd) begin
                exp = {16'(base + 2 * k + 1), 16'(base + 2 * k)};
                if (wr_data !== exp) begin
                    if (mism == 0) $display("  first bad word k=%0d got 0x%0h exp 0x%0h", k, wr_data, exp);
                    mism++;
                end
            end
            rdy_before |= pix_ready;
            tick();
            if (line_done) dones++;
            if (wr_data_rd) k++;
            cyc++;
        end
        wr_data_rd = 1'b0;
        rdy_after = pix_ready;
        if (k < 512) mism += 512 - k;
        repeat (4) begin
            tick();
            if (line_done) dones++;
        end
    endtask

    initial begin
        int  mism, dones, acc;
        bit  rb, ra;

        vecs[0] = '{row: 13'd5,    pre: 0,   row2: 13'd0,    stall: 1'b0, exp_addr: 25'h0005000, exp_fault: 1'b0};
        vecs[1] = '{row: 13'd5,    pre: 100, row2: 13'd7,    stall: 1'b0, exp_addr: 25'h0007000, exp_fault: 1'b1};
        vecs[2] = '{row: 13'h1ABC, pre: 0,   row2: 13'd0,    stall: 1'b1, exp_addr: 25'h1ABC000, exp_fault: 1'b0};
        vecs[3] = '{row: 13'd3,    pre: 1,   row2: 13'h1FFF, stall: 1'b1, exp_addr: 25'h1FFF000, exp_fault: 1'b1};

        // Reset values, then a reset asserted between edges in the middle of a drain.
        do_reset();
        chk("rst_pix_ready", {63'd0, pix_ready}, 64'd1);
        chk("rst_req", {63'd0, wr_mem_req}, 64'd0);
        chk("rst_addr", {39'd0, wr_mem_addr}, 64'd0);
        chk("rst_len", {54'd0, wr_xfr_len}, 64'd0);
        chk("rst_data", {32'd0, wr_data}, 64'd0);
        chk("rst_fault", {63'd0, wr_frame_fault}, 64'd0);
        send_line(0, 13'd5);
        wait_req();
        wr_mem_grant = 1'b1; tick(); wr_mem_grant = 1'b0; tick();
        wr_data_rd = 1'b1;
        repeat (10) tick();
        wr_data_rd = 1'b0;
        chk("mid_drain_word10", {32'd0, wr_data}, {32'd0, 16'd21, 16'd20});
        #2 mem_rst_n = 1'b0;
        #1;
        chk("async_rst_data", {32'd0, wr_data}, 64'd0);
        chk("async_rst_req", {63'd0, wr_mem_req}, 64'd0);
        chk("async_rst_addr", {39'd0, wr_mem_addr}, 64'd0);
        chk("async_rst_len", {54'd0, wr_xfr_len}, 64'd0);
        chk("async_rst_ready", {63'd0, pix_ready}, 64'd1);
        tick(); tick();
        mem_rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            tick();
            if (line_done) dones++;
        end
        chk("rst_no_line_done", dones, 0);
        chk("rst_no_req", {63'd0, wr_mem_req}, 64'd0);

        // Whole-line vectors.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            if (vecs[v].pre > 0) begin
                for (int i = 0; i < vecs[v].pre; i++) send_pix(16'(1000 + i), i == 0, vecs[v].row);
                send_line(0, vecs[v].row2);
            end else begin
                send_line(0, vecs[v].row);
            end
            chk($sformatf("v%0d_req_e0", v), {63'd0, wr_mem_req}, 64'd0);
            tick();
            chk($sformatf("v%0d_req_e1", v), {63'd0, wr_mem_req}, 64'd0);
            tick();
            chk($sformatf("v%0d_req_e2", v), {63'd0, wr_mem_req}, 64'd1);
            chk($sformatf("v%0d_addr", v), {39'd0, wr_mem_addr}, {39'd0, vecs[v].exp_addr});
            chk($sformatf("v%0d_len", v), {54'd0, wr_xfr_len}, 64'h200);
            drain(0, vecs[v].stall, 1'b0, mism, dones, rb, ra);
            chk($sformatf("v%0d_word_mismatches", v), mism, 0);
            chk($sformatf("v%0d_line_done", v), dones, 1);
            repeat (4) tick();
            chk($sformatf("v%0d_no_extra_req", v), {63'd0, wr_mem_req}, 64'd0);
            chk($sformatf("v%0d_fault", v), {63'd0, wr_frame_fault}, {63'd0, vecs[v].exp_fault});
        end

        // Backpressure with the grant withheld.
        do_reset();
        acc = 0;
        pix_row = 13'd5;
        for (int i = 0; i < 2100; i++) begin
            if (!pix_ready) break;
            pix_valid = 1'b1; pix_data = 16'(i); pix_sol = (i == 0);
            tick();
            acc++;
        end
        pix_valid = 1'b0; pix_sol = 1'b0;
        chk("bp_accepted", acc, 2048);
        repeat (3) tick();
        chk("bp_ready_low", {63'd0, pix_ready}, 64'd0);
        chk("bp_req", {63'd0, wr_mem_req}, 64'd1);
        chk("bp_addr", {39'd0, wr_mem_addr}, 64'h5000);
        drain(0, 1'b0, 1'b0, mism, dones, rb, ra);
        chk("bp_l0_words", mism, 0);
        chk("bp_l0_done", dones, 1);
        chk("bp_ready_before_empty", {63'd0, rb}, 64'd0);
        chk("bp_ready_after_empty", {63'd0, ra}, 64'd1);
        wait_req();
        chk("bp_l1_addr", {39'd0, wr_mem_addr}, 64'h5000);
        drain(1024, 1'b1, 1'b0, mism, dones, rb, ra);
        chk("bp_l1_words", mism, 0);
        chk("bp_l1_done", dones, 1);

        // Stray wr_data_rd in IDLE, then a transfer still starts from word 0.
        do_reset();
        chk("idle_fault_before", {63'd0, wr_frame_fault}, 64'd0);
        wr_data_rd = 1'b1; tick(); wr_data_rd = 1'b0;
        chk("idle_rd_fault", {63'd0, wr_frame_fault}, 64'd1);
        chk("idle_rd_no_req", {63'd0, wr_mem_req}, 64'd0);
        send_line(0, 13'd9);
        wait_req();
        chk("idle_rd_addr", {39'd0, wr_mem_addr}, 64'h9000);
        drain(0, 1'b0, 1'b0, mism, dones, rb, ra);
        chk("idle_rd_words", mism, 0);
        chk("idle_rd_done", dones, 1);

        // Stray wr_data_rd in PRE_XFR.
        do_reset();
        send_line(0, 13'd9);
        wait_req();
        drain(0, 1'b0, 1'b1, mism, dones, rb, ra);
        chk("pre_rd_words", mism, 0);
        chk("pre_rd_done", dones, 1);
        chk("pre_rd_fault", {63'd0, wr_frame_fault}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
